// File: rtl/register_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Decode renames destinations; ROB commits write values back; flush clears all pending status.
module register_status_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        rename_en,
  input  logic [4:0]  rename_regid,
  input  logic [4:0]  rename_vregid,
  input  logic        commit_en,
  input  logic [4:0]  commit_regid,
  input  logic [4:0]  commit_vregid,
  input  logic [31:0] commit_val,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  output logic        rs1_busy,
  output logic [4:0]  rs1_vregid,
  output logic [31:0] rs1_val,
  output logic        rs2_busy,
  output logic [4:0]  rs2_vregid,
  output logic [31:0] rs2_val
);

  logic [31:0] val_r  [32];
  logic        busy_r [32];
  logic [4:0]  tag_r  [32];

  // Resolve one source operand: {busy, vregid, val}, with commit bypass on a tag match.
  function automatic logic [37:0] read_port(
    input logic [4:0]  id,
    input logic        busy,
    input logic [4:0]  tag,
    input logic [31:0] val,
    input logic        c_en,
    input logic [4:0]  c_regid,
    input logic [4:0]  c_vregid,
    input logic [31:0] c_val
  );
    logic [37:0] res;
    res = 38'd0;
    if (id == 5'd0) begin
      res = 38'd0;
    end else if (busy && c_en && (c_regid == id) && (c_vregid == tag)) begin
      res = {1'b0, 5'd0, c_val};
    end else if (busy) begin
      res = {1'b1, tag, 32'd0};
    end else begin
      res = {1'b0, 5'd0, val};
    end
    return res;
  endfunction

  // Storage update: x0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        val_r[i]  <= 32'd0;
        busy_r[i] <= 1'b0;
        tag_r[i]  <= 5'd0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (commit_en && (commit_regid == 5'(i))) begin
          val_r[i] <= commit_val;
        end
        if (flush) begin
          busy_r[i] <= 1'b0;
        end else if (rename_en && (rename_regid == 5'(i))) begin
          busy_r[i] <= 1'b1;
          tag_r[i]  <= rename_vregid;
        end else if (commit_en && (commit_regid == 5'(i)) && (tag_r[i] == commit_vregid)) begin
          // A mismatching tag means a newer writer owns the register.
          busy_r[i] <= 1'b0;
        end
      end
    end
  end

  logic [37:0] rs1_res_s;
  logic [37:0] rs2_res_s;

  // Source read ports see pre-rename, pre-flush state.
  always_comb begin
    rs1_res_s = read_port(rs1_id, busy_r[rs1_id], tag_r[rs1_id], val_r[rs1_id],
                          commit_en, commit_regid, commit_vregid, commit_val);
    rs2_res_s = read_port(rs2_id, busy_r[rs2_id], tag_r[rs2_id], val_r[rs2_id],
                          commit_en, commit_regid, commit_vregid, commit_val);
  end

  assign {rs1_busy, rs1_vregid, rs1_val} = rs1_res_s;
  assign {rs2_busy, rs2_vregid, rs2_val} = rs2_res_s;

endmodule

// File: tb/tb_register_status_file.sv
// Self-checking bench for register_status_file: directed scenarios plus randomized traffic
// checked against a behavioural array model.
module tb_register_status_file;

  logic        clk = 1'b0;
  logic        rst, flush, rename_en, commit_en;
  logic [4:0]  rename_regid, rename_vregid, commit_regid, commit_vregid, rs1_id, rs2_id;
  logic [31:0] commit_val;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rs1_vregid, rs2_vregid;
  logic [31:0] rs1_val, rs2_val;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [4:0]  m_tag  [32];

  always #5 clk = ~clk;

  register_status_file dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rename_en(rename_en), .rename_regid(rename_regid), .rename_vregid(rename_vregid),
    .commit_en(commit_en), .commit_regid(commit_regid), .commit_vregid(commit_vregid),
    .commit_val(commit_val), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_busy(rs1_busy), .rs1_vregid(rs1_vregid), .rs1_val(rs1_val),
    .rs2_busy(rs2_busy), .rs2_vregid(rs2_vregid), .rs2_val(rs2_val)
  );

  // Expected {busy, vregid (0 if not busy), val} for a source id under current inputs.
  function automatic logic [37:0] model_read(input logic [4:0] id);
    if (id == 5'd0) return 38'd0;
    if (m_busy[id] && commit_en && commit_regid == id && commit_vregid == m_tag[id])
      return {1'b0, 5'd0, commit_val};
    if (m_busy[id]) return {1'b1, m_tag[id], 32'd0};
    return {1'b0, 5'd0, m_val[id]};
  endfunction

  task automatic model_update();
    logic clr;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 5'd0;
      end
    end else begin
      clr = 1'b0;
      if (commit_en && commit_regid != 5'd0) begin
        m_val[commit_regid] = commit_val;
        clr = (m_tag[commit_regid] == commit_vregid);
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (clr) m_busy[commit_regid] = 1'b0;
        if (rename_en && rename_regid != 5'd0) begin
          m_busy[rename_regid] = 1'b1;
          m_tag[rename_regid] = rename_vregid;
        end
      end
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; rename_en = 1'b0; commit_en = 1'b0;
    rename_regid = 5'd0; rename_vregid = 5'd0;
    commit_regid = 5'd0; commit_vregid = 5'd0; commit_val = 32'd0;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rename(input logic [4:0] r, input logic [4:0] t);
    idle(); rename_en = 1'b1; rename_regid = r; rename_vregid = t; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); idle();
    rs1_id = 5'd5; rs2_id = 5'd31; #1;
    total_cnt++;
    if ({rs1_busy, rs1_vregid, rs1_val} !== 38'd0) $display("FAIL reset_x5 got %b/%0d/%h want 0/0/0", rs1_busy, rs1_vregid, rs1_val);
    else pass_cnt++;
    total_cnt++;
    if ({rs2_busy, rs2_vregid, rs2_val} !== 38'd0) $display("FAIL reset_x31 got %b/%0d/%h want 0/0/0", rs2_busy, rs2_vregid, rs2_val);
    else pass_cnt++;
    commit_en = 1'b1; commit_regid = 5'd5; commit_vregid = 5'd3; commit_val = 32'hDEADBEEF;
    tick(); idle(); rs1_id = 5'd5; #1;
    total_cnt++;
    if ({rs1_busy, rs1_val} !== {1'b0, 32'hDEADBEEF}) $display("FAIL commit_idle got %b/%h want 0/deadbeef", rs1_busy, rs1_val);
    else pass_cnt++;
  endtask

  task automatic test_rename_commit();
    do_rename(5'd7, 5'd4); rs1_id = 5'd7; #1;
    total_cnt++;
    if ({rs1_busy, rs1_vregid} !== {1'b1, 5'd4}) $display("FAIL rename_vis got %b/%0d want 1/4", rs1_busy, rs1_vregid);
    else pass_cnt++;
    commit_en = 1'b1; commit_regid = 5'd7; commit_vregid = 5'd4; commit_val = 32'h55; #1;
    total_cnt++;
    if ({rs1_busy, rs1_val} !== {1'b0, 32'h55}) $display("FAIL bypass got %b/%h want 0/55", rs1_busy, rs1_val);
    else pass_cnt++;
    tick(); idle(); rs1_id = 5'd7; #1;
    total_cnt++;
    if ({rs1_busy, rs1_val} !== {1'b0, 32'h55}) $display("FAIL commit_stored got %b/%h want 0/55", rs1_busy, rs1_val);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_rename(5'd7, 5'd4);
    do_rename(5'd7, 5'd9);
    commit_en = 1'b1; commit_regid = 5'd7; commit_vregid = 5'd4; commit_val = 32'h11; rs1_id = 5'd7; #1;
    total_cnt++;
    if ({rs1_busy, rs1_vregid} !== {1'b1, 5'd9}) $display("FAIL stale_commit_same got %b/%0d want 1/9", rs1_busy, rs1_vregid);
    else pass_cnt++;
    tick(); idle(); rs1_id = 5'd7; #1;
    total_cnt++;
    if ({rs1_busy, rs1_vregid} !== {1'b1, 5'd9}) $display("FAIL stale_commit_next got %b/%0d want 1/9", rs1_busy, rs1_vregid);
    else pass_cnt++;
    commit_en = 1'b1; commit_regid = 5'd7; commit_vregid = 5'd9; commit_val = 32'h22;
    tick(); idle(); rs1_id = 5'd7; #1;
    total_cnt++;
    if ({rs1_busy, rs1_val} !== {1'b0, 32'h22}) $display("FAIL newest_commit got %b/%h want 0/22", rs1_busy, rs1_val);
    else pass_cnt++;
  endtask

  task automatic test_rename_commit_same();
    do_rename(5'd3, 5'd2);
    rename_en = 1'b1; rename_regid = 5'd3; rename_vregid = 5'd6;
    commit_en = 1'b1; commit_regid = 5'd3; commit_vregid = 5'd2; commit_val = 32'h80;
    tick(); idle(); rs1_id = 5'd3; #1;
    total_cnt++;
    if ({rs1_busy, rs1_vregid} !== {1'b1, 5'd6}) $display("FAIL rename_wins got %b/%0d want 1/6", rs1_busy, rs1_vregid);
    else pass_cnt++;
    flush = 1'b1; tick(); idle(); rs1_id = 5'd3; #1;
    total_cnt++;
    if ({rs1_busy, rs1_val} !== {1'b0, 32'h80}) $display("FAIL val_kept got %b/%h want 0/80", rs1_busy, rs1_val);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    do_rename(5'd1, 5'd1);
    do_rename(5'd2, 5'd2);
    flush = 1'b1; commit_en = 1'b1; commit_regid = 5'd1; commit_vregid = 5'd1; commit_val = 32'h1234;
    rename_en = 1'b1; rename_regid = 5'd4; rename_vregid = 5'd5;
    tick(); idle(); rs1_id = 5'd1; rs2_id = 5'd2; #1;
    total_cnt++;
    if ({rs1_busy, rs1_val} !== {1'b0, 32'h1234}) $display("FAIL flush_commit got %b/%h want 0/1234", rs1_busy, rs1_val);
    else pass_cnt++;
    total_cnt++;
    if ({rs2_busy, rs2_val} !== {1'b0, 32'h0}) $display("FAIL flush_x2 got %b/%h want 0/0", rs2_busy, rs2_val);
    else pass_cnt++;
    rs1_id = 5'd4; #1;
    total_cnt++;
    if (rs1_busy !== 1'b0) $display("FAIL flush_drop_rename got %b want 0", rs1_busy);
    else pass_cnt++;
  endtask

  task automatic test_x0();
    rename_en = 1'b1; rename_regid = 5'd0; rename_vregid = 5'd8;
    commit_en = 1'b1; commit_regid = 5'd0; commit_val = 32'hFFFFFFFF; rs1_id = 5'd0;
    tick(); idle(); rs1_id = 5'd0; #1;
    total_cnt++;
    if ({rs1_busy, rs1_val} !== {1'b0, 32'h0}) $display("FAIL x0 got %b/%h want 0/0", rs1_busy, rs1_val);
    else pass_cnt++;
    commit_en = 1'b1; commit_regid = 5'd9; commit_vregid = 5'd0; commit_val = 32'h99;
    tick(); idle();
    rename_en = 1'b1; rename_regid = 5'd9; rename_vregid = 5'd3; rs1_id = 5'd9; #1;
    total_cnt++;
    if ({rs1_busy, rs1_val} !== {1'b0, 32'h99}) $display("FAIL pre_rename got %b/%h want 0/99", rs1_busy, rs1_val);
    else pass_cnt++;
    tick(); idle(); rs1_id = 5'd9; #1;
    total_cnt++;
    if ({rs1_busy, rs1_vregid} !== {1'b1, 5'd3}) $display("FAIL post_rename got %b/%0d want 1/3", rs1_busy, rs1_vregid);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [37:0] e1, e2, g1, g2;
    for (int n = 0; n < 2000; n++) begin
      idle();
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      rename_en = $urandom_range(0, 1);
      rename_regid  = 5'($urandom_range(0, 7));
      rename_vregid = 5'($urandom_range(0, 31));
      commit_en = $urandom_range(0, 1);
      commit_regid  = 5'($urandom_range(0, 7));
      commit_vregid = ($urandom_range(0, 2) != 0) ? m_tag[commit_regid] : 5'($urandom_range(0, 31));
      commit_val = $urandom;
      rs1_id = 5'($urandom_range(0, 8));
      rs2_id = 5'($urandom_range(0, 8));
      #1;
      e1 = model_read(rs1_id);
      e2 = model_read(rs2_id);
      g1 = {rs1_busy, rs1_busy ? rs1_vregid : 5'd0, rs1_val};
      g2 = {rs2_busy, rs2_busy ? rs2_vregid : 5'd0, rs2_val};
      total_cnt++;
      if (g1 !== e1) $display("FAIL rand_rs1 cyc %0d id %0d got %h want %h", n, rs1_id, g1, e1);
      else pass_cnt++;
      total_cnt++;
      if (g2 !== e2) $display("FAIL rand_rs2 cyc %0d id %0d got %h want %h", n, rs2_id, g2, e2);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    idle(); rs1_id = 5'd0; rs2_id = 5'd0;
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 5'd0;
    end
    @(posedge clk); #1;
    test_reset();
    test_rename_commit();
    test_back_to_back();
    test_rename_commit_same();
    test_flush();
    test_x0();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
